// File: rtl/loop_sequencer.sv
// Program-counter and loop-nesting controller: walks the instruction memory,
// issues body instructions and drives push/next/finish strobes to the loop unit.
module loop_sequencer #(
    parameter int unsigned BITS                  = 15,
    parameter int unsigned PC_BITS               = 10,
    parameter int unsigned LOOP_LOG_CNT          = 3,
    parameter int unsigned SUPERSCALAR_LOG_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [PC_BITS-1:0]               start_pc,
    output logic [PC_BITS-1:0]               pc,
    input  logic                             instr_is_loop,
    input  logic                             instr_is_halt,
    input  logic                             instr_loop_independent,
    input  logic [PC_BITS-1:0]               instr_loop_body_len,
    input  logic [BITS-1:0]                  instr_loop_iter_count,
    output logic                             issue_valid,
    input  logic                             queue_ready,
    output logic [SUPERSCALAR_LOG_WIDTH:0]   issue_copies,
    output logic                             loop_clear,
    output logic                             loop_should_increment,
    output logic                             loop_create,
    output logic                             loop_next_iter,
    output logic                             loop_finish,
    output logic [BITS-1:0]                  loop_iteration_count,
    output logic                             loop_is_independent,
    input  logic                             loop_done,
    input  logic [SUPERSCALAR_LOG_WIDTH-1:0] loop_copy_count,
    output logic                             busy,
    output logic                             halted,
    output logic                             error
);
    localparam int unsigned LOOP_CNT = 1 << LOOP_LOG_CNT;
    localparam int unsigned DEPTH_W  = LOOP_LOG_CNT + 1;
    localparam int unsigned COPY_W   = SUPERSCALAR_LOG_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_END_CHECK,
        S_HALT,
        S_ERROR
    } state_e;

    state_e               state_q, state_d;
    logic [PC_BITS-1:0]   pc_q, pc_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic [PC_BITS-1:0]   body_start_q [LOOP_CNT];
    logic [PC_BITS-1:0]   body_start_d [LOOP_CNT];
    logic [PC_BITS-1:0]   body_end_q   [LOOP_CNT];
    logic [PC_BITS-1:0]   body_end_d   [LOOP_CNT];

    logic [LOOP_LOG_CNT-1:0] push_idx, top_idx, under_idx;
    logic [PC_BITS-1:0]      top_start, top_end, under_end, pc_inc;
    logic                    depth_nz, depth_gt1, stack_full, bad_loop;

    // Stack views: top entry and the one beneath it (the new top after a pop)
    assign push_idx   = LOOP_LOG_CNT'(depth_q);
    assign top_idx    = LOOP_LOG_CNT'(depth_q - DEPTH_W'(1));
    assign under_idx  = LOOP_LOG_CNT'(depth_q - DEPTH_W'(2));
    assign top_start  = body_start_q[top_idx];
    assign top_end    = body_end_q[top_idx];
    assign under_end  = body_end_q[under_idx];
    assign pc_inc     = pc_q + PC_BITS'(1);
    assign depth_nz   = (depth_q != '0);
    assign depth_gt1  = (depth_q > DEPTH_W'(1));
    assign stack_full = (depth_q == DEPTH_W'(LOOP_CNT));
    assign bad_loop   = (instr_loop_body_len == '0) || (instr_loop_iter_count == '0) || stack_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            depth_q <= '0;
            for (int unsigned i = 0; i < LOOP_CNT; i++) begin
                body_start_q[i] <= '0;
                body_end_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            depth_q      <= depth_d;
            body_start_q <= body_start_d;
            body_end_q   <= body_end_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        depth_d        = depth_q;
        body_start_d   = body_start_q;
        body_end_d     = body_end_q;
        issue_valid    = 1'b0;
        issue_copies   = COPY_W'(1);
        loop_create    = 1'b0;
        loop_next_iter = 1'b0;
        loop_finish    = 1'b0;
        loop_clear     = reset;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d       = start_pc;
                    depth_d    = '0;
                    loop_clear = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (instr_is_halt) begin
                    state_d = S_HALT;
                end else if (instr_is_loop) begin
                    if (bad_loop) begin
                        state_d = S_ERROR;
                    end else begin
                        body_start_d[push_idx] = pc_inc;
                        body_end_d[push_idx]   = pc_q + instr_loop_body_len;
                        loop_create            = 1'b1;
                        pc_d                   = pc_inc;
                        depth_d                = depth_q + DEPTH_W'(1);
                    end
                end else begin
                    issue_valid  = 1'b1;
                    issue_copies = depth_nz ? COPY_W'(loop_copy_count) + COPY_W'(1) : COPY_W'(1);
                    if (queue_ready) begin
                        if (depth_nz && (pc_q == top_end)) begin
                            if (loop_done) begin
                                loop_finish = 1'b1;
                                depth_d     = depth_q - DEPTH_W'(1);
                                if (depth_gt1 && (under_end == pc_q)) begin
                                    state_d = S_END_CHECK;
                                end else begin
                                    pc_d = pc_inc;
                                end
                            end else begin
                                loop_next_iter = 1'b1;
                                pc_d           = top_start;
                            end
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                end
            end
            // Outer loop sharing the end pc: decide its fate without reissuing
            S_END_CHECK: begin
                state_d = S_RUN;
                if (depth_nz) begin
                    if (loop_done) begin
                        loop_finish = 1'b1;
                        depth_d     = depth_q - DEPTH_W'(1);
                        if (depth_gt1 && (under_end == pc_q)) begin
                            state_d = S_END_CHECK;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end else begin
                        loop_next_iter = 1'b1;
                        pc_d           = top_start;
                    end
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: begin
            end
        endcase

        loop_should_increment = loop_create | loop_next_iter | loop_finish;
    end

    assign pc                   = pc_q;
    assign loop_iteration_count = instr_loop_iter_count;
    assign loop_is_independent  = instr_loop_independent;
    assign busy                 = (state_q == S_RUN) || (state_q == S_END_CHECK);
    assign halted               = (state_q == S_HALT);
    assign error                = (state_q == S_ERROR);

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed bench for loop_sequencer with a behavioural stand-in for the loop unit.
module tb_loop_sequencer;
    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  start_pc;
    logic [9:0]  pc;
    logic        instr_is_loop, instr_is_halt, instr_loop_independent;
    logic [9:0]  instr_loop_body_len;
    logic [14:0] instr_loop_iter_count;
    logic        issue_valid, queue_ready;
    logic [2:0]  issue_copies;
    logic        loop_clear, loop_should_increment, loop_create, loop_next_iter, loop_finish;
    logic [14:0] loop_iteration_count;
    logic        loop_is_independent;
    logic        loop_done;
    logic [1:0]  loop_copy_count;
    logic        busy, halted, error;

    loop_sequencer dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .start_pc               (start_pc),
        .pc                     (pc),
        .instr_is_loop          (instr_is_loop),
        .instr_is_halt          (instr_is_halt),
        .instr_loop_independent (instr_loop_independent),
        .instr_loop_body_len    (instr_loop_body_len),
        .instr_loop_iter_count  (instr_loop_iter_count),
        .issue_valid            (issue_valid),
        .queue_ready            (queue_ready),
        .issue_copies           (issue_copies),
        .loop_clear             (loop_clear),
        .loop_should_increment  (loop_should_increment),
        .loop_create            (loop_create),
        .loop_next_iter         (loop_next_iter),
        .loop_finish            (loop_finish),
        .loop_iteration_count   (loop_iteration_count),
        .loop_is_independent    (loop_is_independent),
        .loop_done              (loop_done),
        .loop_copy_count        (loop_copy_count),
        .busy                   (busy),
        .halted                 (halted),
        .error                  (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory (16 words, unused words are halts)
    logic        m_is_loop [16];
    logic        m_is_halt [16];
    logic        m_indep   [16];
    logic [9:0]  m_len     [16];
    logic [14:0] m_cnt     [16];

    assign instr_is_loop          = m_is_loop[pc[3:0]];
    assign instr_is_halt          = m_is_halt[pc[3:0]];
    assign instr_loop_independent = m_indep[pc[3:0]];
    assign instr_loop_body_len    = m_len[pc[3:0]];
    assign instr_loop_iter_count  = m_cnt[pc[3:0]];

    // Loop-unit model: remaining iterations per level, up to 4 copies for independent loops
    logic [14:0] lm_rem [8];
    logic        lm_ind [8];
    int          lm_depth;
    int          lm_copies;
    logic [14:0] lm_top_rem;

    always_comb begin
        lm_copies       = 1;
        lm_top_rem      = '0;
        loop_done       = 1'b0;
        loop_copy_count = '0;
        if (lm_depth > 0) begin
            lm_top_rem = lm_rem[lm_depth-1];
            if (lm_ind[lm_depth-1]) lm_copies = (lm_top_rem >= 15'd4) ? 4 : int'(lm_top_rem);
            loop_done       = (int'(lm_top_rem) <= lm_copies);
            loop_copy_count = 2'(lm_copies - 1);
        end
    end

    always @(posedge clk) begin
        if (reset || loop_clear) begin
            lm_depth <= 0;
        end else if (loop_create && lm_depth < 8) begin
            lm_rem[lm_depth] <= loop_iteration_count;
            lm_ind[lm_depth] <= loop_is_independent;
            lm_depth         <= lm_depth + 1;
        end else if (loop_next_iter && lm_depth > 0) begin
            lm_rem[lm_depth-1] <= lm_rem[lm_depth-1] - 15'(lm_copies);
        end else if (loop_finish && lm_depth > 0) begin
            lm_depth <= lm_depth - 1;
        end
    end

    int passed, total;
    int iss_pc[$];
    int iss_cp[$];
    int n_create, n_next, n_finish, n_endcheck;
    int halt_cyc, err_cyc, first_next_cyc, last_finish_cyc;
    int excl_bad, stall_bad, cp_not1;
    logic ok;

    int exp_flat[7] = '{0, 2, 3, 2, 3, 2, 3};
    int exp_nest[4] = '{2, 2, 2, 2};

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) begin
            m_is_loop[i] = 1'b0; m_is_halt[i] = 1'b1; m_indep[i] = 1'b0;
            m_len[i] = '0; m_cnt[i] = '0;
        end
    endtask

    task automatic set_plain(input int a);
        m_is_halt[a] = 1'b0; m_is_loop[a] = 1'b0;
    endtask

    task automatic set_loop(input int a, input int cnt, input int len, input logic ind);
        m_is_halt[a] = 1'b0; m_is_loop[a] = 1'b1; m_indep[a] = ind;
        m_cnt[a] = 15'(cnt); m_len[a] = 10'(len);
    endtask

    task automatic load_flat();
        clear_prog();
        set_plain(0); set_loop(1, 3, 2, 1'b0); set_plain(2); set_plain(3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; queue_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Start at pc 0 and record activity per cycle until halt/error/reset or budget
    task automatic run_prog(input int maxc, input int stall_from, input int stall_n,
                            input int stall_pc, input int rst_at);
        int nstb;
        iss_pc.delete(); iss_cp.delete();
        n_create = 0; n_next = 0; n_finish = 0; n_endcheck = 0;
        halt_cyc = 0; err_cyc = 0; first_next_cyc = 0; last_finish_cyc = 0;
        excl_bad = 0; stall_bad = 0; cp_not1 = 0;
        @(negedge clk);
        start = 1'b1; start_pc = '0; queue_ready = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            start       = 1'b0;
            queue_ready = !(c >= stall_from && c < stall_from + stall_n);
            reset       = (c == rst_at);
            #1;
            if (reset) break;
            if (halted) begin halt_cyc = c; break; end
            if (error) begin err_cyc = c; break; end
            nstb = int'(loop_create) + int'(loop_next_iter) + int'(loop_finish);
            if (nstb > 1 || (loop_should_increment !== (nstb == 1))) excl_bad++;
            if (!queue_ready && (issue_valid !== 1'b1 || int'(pc) != stall_pc || nstb != 0)) stall_bad++;
            if (issue_valid && queue_ready) begin
                iss_pc.push_back(int'(pc));
                iss_cp.push_back(int'(issue_copies));
                if (issue_copies != 3'd1) cp_not1++;
            end
            if (loop_create) n_create++;
            if (loop_next_iter) begin
                n_next++;
                if (first_next_cyc == 0) first_next_cyc = c;
            end
            if (loop_finish) begin n_finish++; last_finish_cyc = c; end
            if (busy && !issue_valid && !instr_is_loop && !instr_is_halt) n_endcheck++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start_pc = '0; queue_ready = 1'b1;
        load_flat();
        @(negedge clk); @(negedge clk);
        #1;
        total++; if (loop_clear !== 1'b1) $display("FAIL rst_loop_clear: got %b want 1", loop_clear); else passed++;
        reset = 1'b0;
        #1;
        total++;
        if ({pc, busy, halted, error, issue_valid, issue_copies, loop_should_increment, loop_create,
             loop_next_iter, loop_finish, loop_clear} !== {10'd0, 4'b0000, 3'd1, 5'b00000})
            $display("FAIL rst_outputs: pc=%0d busy=%b halted=%b error=%b iv=%b cp=%0d strobes=%b%b%b%b clr=%b want all 0, cp=1",
                     pc, busy, halted, error, issue_valid, issue_copies, loop_should_increment,
                     loop_create, loop_next_iter, loop_finish, loop_clear);
        else passed++;
        start = 1'b1;
        #1;
        total++; if (loop_clear !== 1'b1) $display("FAIL start_loop_clear: got %b want 1", loop_clear); else passed++;
        start = 1'b0;
        #1;
    endtask

    task automatic test_flat();
        do_reset();
        load_flat();
        run_prog(40, 0, 0, 0, 0);
        ok = (iss_pc.size() == 7);
        if (ok) foreach (exp_flat[i]) if (iss_pc[i] != exp_flat[i]) ok = 1'b0;
        total++; if (ok !== 1'b1) $display("FAIL flat_trace: got %p want %p", iss_pc, exp_flat); else passed++;
        total++; if ({n_create, n_next, n_finish} !== {32'd1, 32'd2, 32'd1})
            $display("FAIL flat_strobes: got create=%0d next=%0d finish=%0d want 1/2/1", n_create, n_next, n_finish); else passed++;
        total++; if (halt_cyc !== 10) $display("FAIL flat_halt_cycle: got %0d want 10", halt_cyc); else passed++;
        total++; if (first_next_cyc !== 4) $display("FAIL flat_jump_cycle: got %0d want 4", first_next_cyc); else passed++;
        total++; if (excl_bad !== 0 || cp_not1 !== 0)
            $display("FAIL flat_excl_copies: got excl_bad=%0d cp_not1=%0d want 0/0", excl_bad, cp_not1); else passed++;
        // HALT is sticky and ignores start
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        total++; if ({halted, busy, pc} !== {1'b1, 1'b0, 10'd4})
            $display("FAIL halt_sticky: got halted=%b busy=%b pc=%0d want 1/0/4", halted, busy, pc); else passed++;
    endtask

    task automatic test_nested();
        do_reset();
        clear_prog();
        set_loop(0, 2, 2, 1'b0); set_loop(1, 2, 1, 1'b0); set_plain(2);
        run_prog(40, 0, 0, 0, 0);
        ok = (iss_pc.size() == 4);
        if (ok) foreach (exp_nest[i]) if (iss_pc[i] != exp_nest[i]) ok = 1'b0;
        total++; if (ok !== 1'b1) $display("FAIL nest_trace: got %p want %p", iss_pc, exp_nest); else passed++;
        total++; if (n_endcheck !== 2) $display("FAIL nest_endcheck: got %0d want 2", n_endcheck); else passed++;
        total++; if ({n_create, n_next, n_finish} !== {32'd3, 32'd3, 32'd3})
            $display("FAIL nest_strobes: got create=%0d next=%0d finish=%0d want 3/3/3", n_create, n_next, n_finish); else passed++;
        total++; if (last_finish_cyc !== 9 || halt_cyc !== 11)
            $display("FAIL nest_timing: got outer_finish=%0d halt=%0d want 9/11", last_finish_cyc, halt_cyc); else passed++;
        total++; if (excl_bad !== 0 || cp_not1 !== 0)
            $display("FAIL nest_excl_copies: got excl_bad=%0d cp_not1=%0d want 0/0", excl_bad, cp_not1); else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        load_flat();
        run_prog(40, 4, 3, 3, 0);
        total++; if (stall_bad !== 0) $display("FAIL stall_hold: got %0d bad stall cycles want 0", stall_bad); else passed++;
        total++; if (first_next_cyc !== 7) $display("FAIL stall_jump_cycle: got %0d want 7", first_next_cyc); else passed++;
        ok = (iss_pc.size() == 7);
        if (ok) foreach (exp_flat[i]) if (iss_pc[i] != exp_flat[i]) ok = 1'b0;
        total++; if (ok !== 1'b1) $display("FAIL stall_trace: got %p want %p", iss_pc, exp_flat); else passed++;
        total++; if (halt_cyc !== 13) $display("FAIL stall_halt_cycle: got %0d want 13", halt_cyc); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        clear_prog();
        for (int i = 0; i < 9; i++) set_loop(i, 2, 10, 1'b0);
        run_prog(40, 0, 0, 0, 0);
        total++; if (err_cyc !== 10 || n_create !== 8)
            $display("FAIL overflow: got err_cycle=%0d creates=%0d want 10/8", err_cyc, n_create); else passed++;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        total++; if ({error, halted, busy, pc} !== {3'b100, 10'd8})
            $display("FAIL error_sticky: got error=%b halted=%b busy=%b pc=%0d want 1/0/0/8", error, halted, busy, pc); else passed++;
    endtask

    task automatic test_bad_loop();
        do_reset();
        clear_prog();
        set_plain(0); set_loop(1, 3, 0, 1'b0); set_plain(2);
        run_prog(40, 0, 0, 0, 0);
        total++; if (err_cyc !== 3 || n_create !== 0)
            $display("FAIL bad_len: got err_cycle=%0d creates=%0d want 3/0", err_cyc, n_create); else passed++;
        do_reset();
        clear_prog();
        set_loop(0, 0, 2, 1'b0); set_plain(1); set_plain(2);
        run_prog(40, 0, 0, 0, 0);
        total++; if (err_cyc !== 2 || n_create !== 0)
            $display("FAIL bad_count: got err_cycle=%0d creates=%0d want 2/0", err_cyc, n_create); else passed++;
    endtask

    task automatic test_independent();
        do_reset();
        clear_prog();
        set_loop(0, 6, 1, 1'b1); set_plain(1);
        run_prog(40, 0, 0, 0, 0);
        ok = (iss_pc.size() == 2) && (iss_cp.size() == 2);
        if (ok) ok = (iss_pc[0] == 1) && (iss_pc[1] == 1) && (iss_cp[0] == 4) && (iss_cp[1] == 2);
        total++; if (ok !== 1'b1) $display("FAIL indep_issue: got pcs %p copies %p want pcs 1,1 copies 4,2", iss_pc, iss_cp); else passed++;
        total++; if ({n_next, n_finish, halt_cyc} !== {32'd1, 32'd1, 32'd5})
            $display("FAIL indep_strobes: got next=%0d finish=%0d halt=%0d want 1/1/5", n_next, n_finish, halt_cyc); else passed++;
    endtask

    task automatic test_reset_restart();
        do_reset();
        load_flat();
        run_prog(40, 0, 0, 0, 5);
        total++; if (loop_clear !== 1'b1) $display("FAIL midrst_loop_clear: got %b want 1", loop_clear); else passed++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if ({busy, halted, error, issue_valid, pc} !== {4'b0000, 10'd0})
            $display("FAIL midrst_idle: got busy=%b halted=%b error=%b iv=%b pc=%0d want 0/0/0/0/0",
                     busy, halted, error, issue_valid, pc); else passed++;
        run_prog(40, 0, 0, 0, 0);
        ok = (iss_pc.size() == 7);
        if (ok) foreach (exp_flat[i]) if (iss_pc[i] != exp_flat[i]) ok = 1'b0;
        total++; if (ok !== 1'b1) $display("FAIL restart_trace: got %p want %p", iss_pc, exp_flat); else passed++;
        total++; if ({n_create, n_next, n_finish, halt_cyc} !== {32'd1, 32'd2, 32'd1, 32'd10})
            $display("FAIL restart_strobes: got create=%0d next=%0d finish=%0d halt=%0d want 1/2/1/10",
                     n_create, n_next, n_finish, halt_cyc); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_flat();
        test_nested();
        test_stall();
        test_overflow();
        test_bad_loop();
        test_independent();
        test_reset_restart();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
